mmio_uart_bridge: RTL and testbench

MMIO_UART_BRIDGE -- requirements
Module: mmio_uart_bridge

---
 rtl/mmio_uart_bridge.sv | 228 ++++++++++++++++++++++
 tb/tb_mmio_uart_bridge.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_bridge.sv
`timescale 1ns/1ps
// mmio_uart_bridge
//   Byte-wide register port in front of a 16-entry TX FIFO feeding an 8N1
//   serializer, and a 16-entry RX FIFO filled from a host byte stream.
//
//   Ports
//     clk_in, rst_in          clock, asynchronous active-low reset
//     io_en/io_sel/io_wr      one register access per cycle when io_en = 1.
//                             There is no valid/ready handshake: an access
//                             with io_en = 1 always completes in that cycle.
//     io_din, io_dout         write data, registered read data (1-cycle latency)
//     rx_data, rx_valid       incoming host bytes (valid-only, no backpressure)
//     tx, tx_busy             serial output (idles high), frame in progress
//     prog_end, prog_end_code one-cycle pulse and latched code on sel-4 write
//     tx_overflow             sticky: a TX push was dropped on a full FIFO
//
//   Register map
//     sel 0  W: push TX FIFO     R: pop RX FIFO (8'h00 when empty)
//     sel 4  W: end-of-program   R: {5'b0, tx_overflow, rx_empty, tx_full}
//     other  W: ignored          R: 8'h00
module mmio_uart_bridge #(
  parameter int SYS_CLK_FREQ = 140000000,
  parameter int BAUD_RATE    = 115200,
  parameter int FIFO_AW      = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       io_en,
  input  logic [2:0] io_sel,
  input  logic       io_wr,
  input  logic [7:0] io_din,
  output logic [7:0] io_dout,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       tx,
  output logic       tx_busy,
  output logic       prog_end,
  output logic [7:0] prog_end_code,
  output logic       tx_overflow
);

  localparam int CLKS_PER_BIT = SYS_CLK_FREQ / BAUD_RATE;
  localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int DEPTH        = 1 << FIFO_AW;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  // ---------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------
  logic wr_tx, rd_rx, rd_st, wr_pe, rd_any;
  assign wr_tx  = io_en &  io_wr & (io_sel == 3'd0);
  assign rd_rx  = io_en & ~io_wr & (io_sel == 3'd0);
  assign rd_st  = io_en & ~io_wr & (io_sel == 3'd4);
  assign wr_pe  = io_en &  io_wr & (io_sel == 3'd4);
  assign rd_any = io_en & ~io_wr;

  // ---------------------------------------------------------------------
  // FIFOs: FIFO_AW+1-bit pointers; the extra MSB separates full from empty.
  // All full/empty decisions use start-of-cycle pointers, so a pop in the
  // same cycle never makes room for a push.
  // ---------------------------------------------------------------------
  logic [7:0]       tx_mem [DEPTH];
  logic [7:0]       rx_mem [DEPTH];
  logic [FIFO_AW:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
  logic             tx_full, tx_empty, rx_full, rx_empty;
  logic             tx_push, tx_pop, rx_push, rx_pop;
  state_e           state_q;

  assign tx_full  = (tx_wp_q[FIFO_AW] != tx_rp_q[FIFO_AW]) &&
                    (tx_wp_q[FIFO_AW-1:0] == tx_rp_q[FIFO_AW-1:0]);
  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign rx_full  = (rx_wp_q[FIFO_AW] != rx_rp_q[FIFO_AW]) &&
                    (rx_wp_q[FIFO_AW-1:0] == rx_rp_q[FIFO_AW-1:0]);
  assign rx_empty = (rx_wp_q == rx_rp_q);

  assign tx_push = wr_tx & ~tx_full;
  assign tx_pop  = (state_q == IDLE) & ~tx_empty;
  assign rx_push = rx_valid & ~rx_full;
  assign rx_pop  = rd_rx & ~rx_empty;

  // Storage is not reset: only the pointers define what is valid.
  always_ff @(posedge clk_in) begin
    if (tx_push) tx_mem[tx_wp_q[FIFO_AW-1:0]] <= io_din;
    if (rx_push) rx_mem[rx_wp_q[FIFO_AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      tx_wp_q <= '0;
      tx_rp_q <= '0;
      rx_wp_q <= '0;
      rx_rp_q <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
      if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
      if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
      if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Register-side state: read data, overflow flag, end-of-program
  // ---------------------------------------------------------------------
  logic [7:0] io_dout_q, io_dout_d;
  logic       tx_ovf_q, tx_ovf_d;
  logic       prog_end_q;
  logic [7:0] prog_end_code_q, prog_end_code_d;

  always_comb begin
    io_dout_d = io_dout_q;
    if (rd_rx) begin
      // Empty pop returns zero even if a byte is being pushed this cycle.
      io_dout_d = rx_empty ? 8'h00 : rx_mem[rx_rp_q[FIFO_AW-1:0]];
    end else if (rd_st) begin
      io_dout_d = {5'b0, tx_ovf_q, rx_empty, tx_full};
    end else if (rd_any) begin
      io_dout_d = 8'h00;
    end
  end

  always_comb begin
    tx_ovf_d = tx_ovf_q;
    if (wr_tx && tx_full)        tx_ovf_d = 1'b1;  // new overflow wins
    else if (wr_pe && io_din[2]) tx_ovf_d = 1'b0;
  end

  assign prog_end_code_d = wr_pe ? io_din : prog_end_code_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      io_dout_q       <= 8'h00;
      tx_ovf_q        <= 1'b0;
      prog_end_q      <= 1'b0;
      prog_end_code_q <= 8'h00;
    end else begin
      io_dout_q       <= io_dout_d;
      tx_ovf_q        <= tx_ovf_d;
      prog_end_q      <= wr_pe;
      prog_end_code_q <= prog_end_code_d;
    end
  end

  // ---------------------------------------------------------------------
  // Serializer: IDLE pops a byte, then START / 8 x DATA / STOP, each
  // CLKS_PER_BIT cycles. The IDLE pop cycle is the one idle-high cycle
  // between back-to-back frames. tx and tx_busy are registered here.
  // ---------------------------------------------------------------------
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_idx_q;
  logic [7:0]        shift_q;
  logic              tx_q, tx_busy_q;
  logic              baud_last;

  assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
      tx_busy_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          baud_q <= '0;
          if (tx_pop) begin
            shift_q   <= tx_mem[tx_rp_q[FIFO_AW-1:0]];
            state_q   <= START;
            tx_q      <= 1'b0;
            tx_busy_q <= 1'b1;
          end
        end
        START: begin
          if (baud_last) begin
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            tx_q      <= shift_q[0];
            state_q   <= DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              // shift_q[0] is the bit on the line; expose the next one.
              bit_idx_q <= bit_idx_q + 1'b1;
              tx_q      <= shift_q[1];
              shift_q   <= {1'b0, shift_q[7:1]};
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_q    <= '0;
            tx_busy_q <= 1'b0;
            state_q   <= IDLE;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          tx_q      <= 1'b1;
          tx_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign io_dout       = io_dout_q;
  assign tx            = tx_q;
  assign tx_busy       = tx_busy_q;
  assign prog_end      = prog_end_q;
  assign prog_end_code = prog_end_code_q;
  assign tx_overflow   = tx_ovf_q;

endmodule

// File: tb/tb_mmio_uart_bridge.sv
`timescale 1ns/1ps
// Bench for mmio_uart_bridge at SYS_CLK_FREQ=100, BAUD_RATE=10 (10 clocks/bit).
// A queue-based model advances on each rising edge; a compare process checks
// every DUT output against it on each falling edge. Directed sections add
// hand-computed literal expectations.
module tb_mmio_uart_bridge;

  localparam int CPB = 10;

  // ---------------- clock / reset ----------------
  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic       io_en = 1'b0;
  logic [2:0] io_sel = 3'd0;
  logic       io_wr = 1'b0;
  logic [7:0] io_din = 8'h00;
  logic [7:0] io_dout;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx, tx_busy, prog_end, tx_overflow;
  logic [7:0] prog_end_code;

  always #5 clk_in = ~clk_in;

  mmio_uart_bridge #(.SYS_CLK_FREQ(100), .BAUD_RATE(10), .FIFO_AW(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .io_en(io_en), .io_sel(io_sel), .io_wr(io_wr), .io_din(io_din),
    .io_dout(io_dout), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx(tx), .tx_busy(tx_busy), .prog_end(prog_end),
    .prog_end_code(prog_end_code), .tx_overflow(tx_overflow)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_txq[$];
  logic [7:0] m_rxq[$];
  bit         m_busy;
  int         m_cnt;      // cycles since frame start, 0..10*CPB-1
  logic [7:0] m_byte;
  logic [7:0] m_dout, m_code;
  bit         m_pe, m_ovf;
  bit         s_txfull, s_rxempty, s_rxfull;
  logic [7:0] s_stat;

  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      m_txq.delete(); m_rxq.delete();
      m_busy = 0; m_cnt = 0; m_byte = 8'h00;
      m_dout = 8'h00; m_code = 8'h00; m_pe = 0; m_ovf = 0;
    end else begin
      s_txfull  = (m_txq.size() == 16);
      s_rxempty = (m_rxq.size() == 0);
      s_rxfull  = (m_rxq.size() == 16);
      s_stat    = {5'b0, m_ovf, s_rxempty, s_txfull};
      // serializer: a frame is 10 bit-times; one idle cycle precedes each pop
      if (m_busy) begin
        m_cnt++;
        if (m_cnt == 10 * CPB) m_busy = 0;
      end else if (m_txq.size() != 0) begin
        m_byte = m_txq.pop_front();
        m_busy = 1;
        m_cnt  = 0;
      end
      m_pe = 0;
      if (io_en) begin
        if (io_wr) begin
          if (io_sel == 3'd0) begin
            if (s_txfull) m_ovf = 1;
            else m_txq.push_back(io_din);
          end else if (io_sel == 3'd4) begin
            m_pe = 1;
            m_code = io_din;
            if (io_din[2]) m_ovf = 0;
          end
        end else begin
          if (io_sel == 3'd0) m_dout = s_rxempty ? 8'h00 : m_rxq.pop_front();
          else if (io_sel == 3'd4) m_dout = s_stat;
          else m_dout = 8'h00;
        end
      end
      if (rx_valid && !s_rxfull) m_rxq.push_back(rx_data);
    end
  end

  function automatic logic model_tx();
    int idx;
    if (!m_busy) return 1'b1;
    idx = m_cnt / CPB;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return m_byte[idx-1];
  endfunction

  // ---------------- scoreboard compare ----------------
  always @(negedge clk_in) begin
    if (rst_in) begin
      check("tx",            {7'b0, tx},          {7'b0, model_tx()});
      check("tx_busy",       {7'b0, tx_busy},     {7'b0, m_busy});
      check("io_dout",       io_dout,             m_dout);
      check("prog_end",      {7'b0, prog_end},    {7'b0, m_pe});
      check("prog_end_code", prog_end_code,       m_code);
      check("tx_overflow",   {7'b0, tx_overflow}, {7'b0, m_ovf});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic io_write(input logic [2:0] sel, input logic [7:0] d);
    io_en = 1'b1; io_wr = 1'b1; io_sel = sel; io_din = d;
    @(negedge clk_in);
    io_en = 1'b0; io_wr = 1'b0;
  endtask

  task automatic io_read(input logic [2:0] sel);
    io_en = 1'b1; io_wr = 1'b0; io_sel = sel;
    @(negedge clk_in);
    io_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_in);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((m_busy || m_txq.size() != 0) && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    check("drain_done", (n < budget) ? 8'h01 : 8'h00, 8'h01);
  endtask

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [9:0] win;
  int         busy_cnt;

  initial begin
    // reset state while held
    idle(3);
    check("rst_tx",      {7'b0, tx},          8'h01);
    check("rst_busy",    {7'b0, tx_busy},     8'h00);
    check("rst_dout",    io_dout,             8'h00);
    check("rst_pe",      {7'b0, prog_end},    8'h00);
    check("rst_code",    prog_end_code,       8'h00);
    check("rst_ovf",     {7'b0, tx_overflow}, 8'h00);
    rst_in = 1'b1;

    // first access right after release: empty status
    io_read(3'd4);
    check("status_after_reset", io_dout, 8'h02);

    // single frame 8'hA5: start, LSB-first data, stop
    io_write(3'd0, 8'hA5);
    win = {1'b1, 8'hA5, 1'b0};
    busy_cnt = 0;
    for (int k = 0; k < 102; k++) begin
      if (tx_busy) busy_cnt++;
      if (k == 0 || k == 101) check("a5_idle", {7'b0, tx}, 8'h01);
      else check("a5_bit", {7'b0, tx}, {7'b0, win[(k-1)/CPB]});
      @(negedge clk_in);
    end
    check("a5_busy_cycles", 8'(busy_cnt), 8'd100);

    // RX path: two bytes then three reads
    rx_valid = 1'b1; rx_data = 8'h31;
    @(negedge clk_in);
    rx_data = 8'h32;
    @(negedge clk_in);
    rx_valid = 1'b0;
    io_read(3'd0); check("rx_rd0", io_dout, 8'h31);
    io_read(3'd0); check("rx_rd1", io_dout, 8'h32);
    io_read(3'd0); check("rx_rd2", io_dout, 8'h00);
    idle(2);
    check("rx_hold", io_dout, 8'h00);

    // end-of-program write
    io_write(3'd4, 8'h07);
    check("pe_pulse", {7'b0, prog_end}, 8'h01);
    check("pe_code",  prog_end_code,    8'h07);
    @(negedge clk_in);
    check("pe_low",   {7'b0, prog_end}, 8'h00);
    io_read(3'd4);
    check("pe_status", io_dout, 8'h02);
    check("pe_busy",   {7'b0, tx_busy}, 8'h00);

    // burst: one frame in flight, then 17 writes; the 17th is dropped
    io_write(3'd0, 8'hE0);
    idle(3);
    for (int i = 0; i < 17; i++) io_write(3'd0, 8'(8'h40 + i));
    io_read(3'd4);
    check("burst_status", io_dout, 8'h07);
    wait_drain(2500);
    io_write(3'd4, 8'h04);
    io_read(3'd4);
    check("ovf_cleared", io_dout, 8'h02);

    // reset during DATA of 8'h55 with 3 bytes queued
    io_write(3'd0, 8'h55);
    io_write(3'd0, 8'h01);
    io_write(3'd0, 8'h02);
    io_write(3'd0, 8'h03);
    idle(25);
    #2 rst_in = 1'b0;
    #1;
    check("abort_tx",   {7'b0, tx},      8'h01);
    check("abort_busy", {7'b0, tx_busy}, 8'h00);
    @(negedge clk_in);
    rst_in = 1'b1;
    io_read(3'd4);
    check("abort_status", io_dout, 8'h02);
    busy_cnt = 0;
    for (int i = 0; i < 250; i++) begin
      if (tx_busy) busy_cnt++;
      @(negedge clk_in);
    end
    check("abort_no_frames", 8'(busy_cnt), 8'd0);

    // RX overflow: 20 bytes, only 16 kept
    for (int i = 0; i < 20; i++) begin
      rx_valid = 1'b1; rx_data = 8'(i);
      @(negedge clk_in);
    end
    rx_valid = 1'b0;
    for (int i = 0; i < 18; i++) begin
      io_read(3'd0);
      check("rx20_rd", io_dout, (i < 16) ? 8'(i) : 8'h00);
    end

    // randomized mix, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      io_en    = 1'($urandom_range(0, 1));
      io_wr    = 1'($urandom_range(0, 1));
      io_din   = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 3))
        0, 1:    io_sel = 3'd0;
        2:       io_sel = 3'd4;
        default: io_sel = 3'($urandom_range(0, 7));
      endcase
      rx_valid = ($urandom_range(0, 9) < 3);
      rx_data  = 8'($urandom_range(0, 255));
      @(negedge clk_in);
    end
    io_en = 1'b0; rx_valid = 1'b0;
    wait_drain(2500);
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
